// File: rtl/q_learning_engine.sv
// Q-learning / SARSA update engine with an internal Q-table that is cleared after reset.
// A transition is scanned over ACTIONS cycles, then one calc cycle and one write cycle follow.
module q_learning_engine #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned FRAC_BITS     = 8,
  parameter int unsigned STATES        = 16,
  parameter int unsigned ACTIONS       = 4,
  parameter int unsigned STATES_WIDTH  = $clog2(STATES),
  parameter int unsigned ACTIONS_WIDTH = $clog2(ACTIONS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_mode,
  input  logic [STATES_WIDTH-1:0]  i_st,
  input  logic [ACTIONS_WIDTH-1:0] i_at,
  input  logic [STATES_WIDTH-1:0]  i_next_st,
  input  logic [ACTIONS_WIDTH-1:0] i_next_at,
  input  logic [DATA_WIDTH-1:0]    i_rt,
  input  logic [DATA_WIDTH-1:0]    i_alpha,
  input  logic [DATA_WIDTH-1:0]    i_gamma,
  output logic                     o_valid,
  output logic [DATA_WIDTH-1:0]    o_q_new,
  output logic [ACTIONS_WIDTH-1:0] o_at_max,
  input  logic [STATES_WIDTH-1:0]  i_rd_st,
  input  logic [ACTIONS_WIDTH-1:0] i_rd_at,
  output logic [DATA_WIDTH-1:0]    o_rd_data
);

  localparam int unsigned DW      = DATA_WIDTH;
  localparam int unsigned ENTRIES = STATES * ACTIONS;
  localparam int unsigned AW      = $clog2(ENTRIES);
  localparam int unsigned TDW     = DW + 2;
  localparam int unsigned GPW     = 2 * DW + 1;
  localparam int unsigned APW     = DW + 1 + TDW;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_SCAN,
    S_CALC,
    S_WRITE
  } state_t;

  function automatic logic [AW-1:0] idx(input logic [STATES_WIDTH-1:0]  s,
                                         input logic [ACTIONS_WIDTH-1:0] a);
    return AW'(s) * AW'(ACTIONS) + AW'(a);
  endfunction

  logic signed [DW-1:0] mem_q [ENTRIES];

  state_t                     state_q, state_d;
  logic [AW-1:0]              clr_q, clr_d;
  logic [ACTIONS_WIDTH-1:0]   scan_k_q, scan_k_d;
  logic [STATES_WIDTH-1:0]    st_q, st_d, nst_q, nst_d;
  logic [ACTIONS_WIDTH-1:0]   at_q, at_d, nat_q, nat_d;
  logic                       mode_q, mode_d;
  logic signed [DW-1:0]       rt_q, rt_d;
  logic [DW-1:0]              alpha_q, alpha_d, gamma_q, gamma_d;
  logic signed [DW-1:0]       max_q, max_d, q_cur_q, q_cur_d, qn_q, qn_d;
  logic [ACTIONS_WIDTH-1:0]   max_idx_q, max_idx_d;
  logic signed [TDW-1:0]      td_q, td_d;
  logic                       ready_q, ready_d, valid_q, valid_d;
  logic signed [DW-1:0]       q_new_q, q_new_d, rd_data_q, rd_data_d;
  logic [ACTIONS_WIDTH-1:0]   at_max_q, at_max_d;

  logic                       wr_en;
  logic [AW-1:0]              wr_addr;
  logic signed [DW-1:0]       wr_data;

  logic signed [DW-1:0]       scan_val;
  logic signed [DW-1:0]       target;
  logic signed [GPW-1:0]      gprod, gsh;
  logic signed [TDW-1:0]      td_calc;
  logic signed [APW-1:0]      aprod, sum;
  logic signed [DW-1:0]       q_sat;

  assign scan_val = mem_q[idx(nst_q, scan_k_q)];

  // Fixed-point datapath: discounted target, TD error, scaled step and saturation.
  always_comb begin
    target  = mode_q ? qn_q : max_q;
    gprod   = GPW'($signed({1'b0, gamma_q})) * GPW'(target);
    gsh     = gprod >>> FRAC_BITS;
    td_calc = TDW'(GPW'(rt_q) + gsh - GPW'(q_cur_q));
    aprod   = APW'($signed({1'b0, alpha_q})) * APW'(td_q);
    sum     = APW'(q_cur_q) + (aprod >>> FRAC_BITS);
    if ((&sum[APW-1:DW-1]) || !(|sum[APW-1:DW-1])) begin
      q_sat = sum[DW-1:0];
    end else if (sum[APW-1]) begin
      q_sat = {1'b1, {(DW-1){1'b0}}};
    end else begin
      q_sat = {1'b0, {(DW-1){1'b1}}};
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    scan_k_d  = scan_k_q;
    st_d      = st_q;
    at_d      = at_q;
    nst_d     = nst_q;
    nat_d     = nat_q;
    mode_d    = mode_q;
    rt_d      = rt_q;
    alpha_d   = alpha_q;
    gamma_d   = gamma_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    q_cur_d   = q_cur_q;
    qn_d      = qn_q;
    td_d      = td_q;
    q_new_d   = q_new_q;
    at_max_d  = at_max_q;
    valid_d   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = clr_q;
    wr_data   = '0;

    case (state_q)
      S_CLEAR: begin
        wr_en = 1'b1;
        clr_d = clr_q + AW'(1);
        if (clr_q == AW'(ENTRIES - 1)) begin
          clr_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (i_valid && ready_q) begin
          st_d     = i_st;
          at_d     = i_at;
          nst_d    = i_next_st;
          nat_d    = i_next_at;
          mode_d   = i_mode;
          rt_d     = i_rt;
          alpha_d  = i_alpha;
          gamma_d  = i_gamma;
          scan_k_d = '0;
          state_d  = S_SCAN;
        end
      end
      S_SCAN: begin
        // Strict > keeps the lowest index on ties.
        if (scan_k_q == '0) begin
          max_d     = scan_val;
          max_idx_d = '0;
          q_cur_d   = mem_q[idx(st_q, at_q)];
          qn_d      = mem_q[idx(nst_q, nat_q)];
        end else if (scan_val > max_q) begin
          max_d     = scan_val;
          max_idx_d = scan_k_q;
        end
        scan_k_d = scan_k_q + ACTIONS_WIDTH'(1);
        if (scan_k_q == ACTIONS_WIDTH'(ACTIONS - 1)) begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        td_d    = td_calc;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        wr_en    = 1'b1;
        wr_addr  = idx(st_q, at_q);
        wr_data  = q_sat;
        q_new_d  = q_sat;
        at_max_d = max_idx_q;
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase

    ready_d   = (state_d == S_IDLE);
    rd_data_d = mem_q[idx(i_rd_st, i_rd_at)];
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= S_CLEAR;
      clr_q     <= '0;
      scan_k_q  <= '0;
      st_q      <= '0;
      at_q      <= '0;
      nst_q     <= '0;
      nat_q     <= '0;
      mode_q    <= 1'b0;
      rt_q      <= '0;
      alpha_q   <= '0;
      gamma_q   <= '0;
      max_q     <= '0;
      max_idx_q <= '0;
      q_cur_q   <= '0;
      qn_q      <= '0;
      td_q      <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      q_new_q   <= '0;
      at_max_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_q     <= clr_d;
      scan_k_q  <= scan_k_d;
      st_q      <= st_d;
      at_q      <= at_d;
      nst_q     <= nst_d;
      nat_q     <= nat_d;
      mode_q    <= mode_d;
      rt_q      <= rt_d;
      alpha_q   <= alpha_d;
      gamma_q   <= gamma_d;
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
      q_cur_q   <= q_cur_d;
      qn_q      <= qn_d;
      td_q      <= td_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      q_new_q   <= q_new_d;
      at_max_q  <= at_max_d;
      rd_data_q <= rd_data_d;
    end
  end

  // A write pending on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !rst_n) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = valid_q;
  assign o_q_new   = q_new_q;
  assign o_at_max  = at_max_q;
  assign o_rd_data = rd_data_q;

endmodule

// File: tb/tb_q_learning_engine.sv
// Self-checking bench for q_learning_engine: directed cases plus random traffic against a table model.
module tb_q_learning_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, o_ready, i_mode, o_valid;
  logic [1:0]  i_st, i_at, i_next_st, i_next_at, o_at_max, i_rd_st, i_rd_at;
  logic [15:0] i_rt, i_alpha, i_gamma, o_q_new, o_rd_data;

  int checks = 0;
  int errors = 0;
  int model[16];

  always #5 clk = ~clk;

  q_learning_engine #(
    .DATA_WIDTH(16), .FRAC_BITS(8), .STATES(4), .ACTIONS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_mode(i_mode),
    .i_st(i_st), .i_at(i_at), .i_next_st(i_next_st), .i_next_at(i_next_at),
    .i_rt(i_rt), .i_alpha(i_alpha), .i_gamma(i_gamma), .o_valid(o_valid),
    .o_q_new(o_q_new), .o_at_max(o_at_max), .i_rd_st(i_rd_st), .i_rd_at(i_rd_at),
    .o_rd_data(o_rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer Q / SARSA update with floor shifts and clamping.
  function automatic void ref_update(input int st, input int at, input int nst, input int nat,
                                     input int rt, input int alpha, input int gamma, input int mode,
                                     output int qn, output int amax);
    int q, mx, target;
    longint g, td, d, s;
    q    = model[st*4+at];
    mx   = model[nst*4];
    amax = 0;
    for (int a = 1; a < 4; a++) begin
      if (model[nst*4+a] > mx) begin
        mx   = model[nst*4+a];
        amax = a;
      end
    end
    target = (mode != 0) ? model[nst*4+nat] : mx;
    g  = (longint'(gamma) * longint'(target)) >>> 8;
    td = longint'(rt) + g - longint'(q);
    d  = (longint'(alpha) * td) >>> 8;
    s  = longint'(q) + d;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    qn = int'(s);
    model[st*4+at] = qn;
  endfunction

  task automatic drive(input int st, input int at, input int nst, input int nat,
                       input int rt, input int alpha, input int gamma, input int mode);
    i_st = 2'(st); i_at = 2'(at); i_next_st = 2'(nst); i_next_at = 2'(nat);
    i_rt = 16'(rt); i_alpha = 16'(alpha); i_gamma = 16'(gamma); i_mode = 1'(mode);
  endtask

  task automatic txn(input string tag, input int st, input int at, input int nst, input int nat,
                     input int rt, input int alpha, input int gamma, input int mode,
                     output int qn, output int amax);
    int old, n;
    @(negedge clk);
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".ready"}, 32'(o_ready), 1);
    drive(st, at, nst, nat, rt, alpha, gamma, mode);
    i_rd_st = 2'(st);
    i_rd_at = 2'(at);
    i_valid = 1'b1;
    old = model[st*4+at];
    ref_update(st, at, nst, nat, rt, alpha, gamma, mode, qn, amax);
    @(posedge clk); #1;
    i_valid = 1'b0;
    n = 1;
    while (!o_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 7);
    chk({tag, ".q_new"}, 32'(o_q_new), 32'(qn & 'hFFFF));
    chk({tag, ".at_max"}, 32'(o_at_max), 32'(amax));
    chk({tag, ".ready_at_valid"}, 32'(o_ready), 1);
    chk({tag, ".rd_old"}, 32'(o_rd_data), 32'(old & 'hFFFF));
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 32'(o_valid), 0);
    chk({tag, ".rd_new"}, 32'(o_rd_data), 32'(qn & 'hFFFF));
  endtask

  task automatic wait_clear(output int n, output bit saw_valid);
    n = 0;
    saw_valid = 1'b0;
    do begin
      @(posedge clk); #1;
      n++;
      if (o_valid) saw_valid = 1'b1;
    end while (!o_ready && n < 40);
  endtask

  task automatic read_chk(input string tag, input int st, input int at, input int exp);
    @(negedge clk);
    i_rd_st = 2'(st);
    i_rd_at = 2'(at);
    @(posedge clk); #1;
    chk(tag, 32'(o_rd_data), 32'(exp & 'hFFFF));
  endtask

  initial begin
    int qn, am, n, c0, prev, nacc;
    int st, at, nst, nat, rt, al, ga, md;
    bit saw;
    int pre_v[4];
    int acc_c[$];
    int exp_q[$];
    int exp_a[$];
    pre_v = '{64, 512, 512, 256};

    rst_n = 1'b1;
    i_valid = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    i_rd_st = '0;
    i_rd_at = '0;
    foreach (model[i]) model[i] = 0;

    // Reset state and clear sequence
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", 32'(o_ready), 0);
    chk("rst.valid", 32'(o_valid), 0);
    chk("rst.q_new", 32'(o_q_new), 0);
    chk("rst.at_max", 32'(o_at_max), 0);
    chk("rst.rd_data", 32'(o_rd_data), 0);
    @(negedge clk);
    rst_n = 1'b0;
    wait_clear(n, saw);
    chk("clear.cycles", 32'(n), 16);
    chk("clear.no_valid", 32'(saw), 0);
    for (int i = 0; i < 16; i++) read_chk("clear.entry", i / 4, i % 4, 0);

    // First update on the cleared table
    txn("t2", 1, 2, 3, 0, 'h0100, 'h0080, 'h0080, 0, qn, am);
    chk("t2.q_const", 32'(o_q_new), 'h0080);
    chk("t2.amax_const", 32'(o_at_max), 0);
    read_chk("t2.table", 1, 2, 'h0080);

    // Tie on argmax, then SARSA target
    for (int a = 0; a < 4; a++) txn("pre", 3, a, 0, 0, pre_v[a], 'h0100, 0, 0, qn, am);
    txn("t3q", 0, 0, 3, 0, 0, 'h0100, 'h0100, 0, qn, am);
    chk("t3q.q_const", 32'(o_q_new), 'h0200);
    chk("t3q.amax_const", 32'(o_at_max), 1);
    txn("t3s", 0, 0, 3, 0, 0, 'h0100, 'h0100, 1, qn, am);
    chk("t3s.q_const", 32'(o_q_new), 'h0040);

    // alpha = 0 still writes and pulses
    txn("a0", 1, 2, 3, 0, 1000, 0, 'h0100, 0, qn, am);
    chk("a0.q_const", 32'(o_q_new), 'h0080);

    // Saturation at both ends
    repeat (3) begin
      txn("satp", 2, 1, 0, 0, 32767, 'h0100, 0, 0, qn, am);
      chk("satp.q_const", 32'(o_q_new), 'h7FFF);
    end
    txn("satg", 2, 1, 2, 0, 32767, 'h0100, 'h0100, 0, qn, am);
    chk("satg.q_const", 32'(o_q_new), 'h7FFF);
    txn("satn", 2, 1, 0, 0, -32768, 'h0100, 0, 0, qn, am);
    chk("satn.q_const", 32'(o_q_new), 'h8000);
    txn("satn2", 2, 1, 2, 1, -32768, 'h0100, 'h0100, 1, qn, am);
    chk("satn2.q_const", 32'(o_q_new), 'h8000);

    // Random transitions
    repeat (24) begin
      txn("rnd", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          int'($signed(16'($urandom))), int'($urandom_range(0, 256)),
          int'($urandom_range(0, 256)), int'($urandom_range(0, 1)), qn, am);
    end

    // Backpressure: i_valid held high with fresh payload every cycle
    prev = -1;
    nacc = 0;
    for (int c = 0; c < 49; c++) begin
      @(negedge clk);
      st = int'($urandom_range(0, 3)); at = int'($urandom_range(0, 3));
      nst = int'($urandom_range(0, 3)); nat = int'($urandom_range(0, 3));
      rt = int'($signed(16'($urandom)));
      al = int'($urandom_range(0, 256)); ga = int'($urandom_range(0, 256));
      md = int'($urandom_range(0, 1));
      drive(st, at, nst, nat, rt, al, ga, md);
      i_valid = 1'b1;
      if (o_ready) begin
        ref_update(st, at, nst, nat, rt, al, ga, md, qn, am);
        acc_c.push_back(c);
        exp_q.push_back(qn);
        exp_a.push_back(am);
        if (prev >= 0) chk("bp.spacing", 32'(c - prev), 7);
        prev = c;
        nacc++;
      end
      @(posedge clk); #1;
      if (o_valid) begin
        chk("bp.valid_has_accept", 32'(acc_c.size() > 0), 1);
        if (acc_c.size() > 0) begin
          c0 = acc_c.pop_front();
          qn = exp_q.pop_front();
          am = exp_a.pop_front();
          chk("bp.latency", 32'(c - c0 + 1), 7);
          chk("bp.q_new", 32'(o_q_new), 32'(qn & 'hFFFF));
          chk("bp.at_max", 32'(o_at_max), 32'(am));
        end
      end
    end
    @(negedge clk);
    i_valid = 1'b0;
    chk("bp.accepts", 32'(nacc), 7);
    chk("bp.drained", 32'(acc_c.size()), 0);

    // Reset during scan discards the update and re-clears
    @(negedge clk);
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    drive(1, 1, 2, 0, 'h0100, 'h0100, 0, 0);
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid.valid", 32'(o_valid), 0);
    chk("mid.ready", 32'(o_ready), 0);
    @(negedge clk);
    rst_n = 1'b0;
    foreach (model[i]) model[i] = 0;
    wait_clear(n, saw);
    chk("mid.clear_cycles", 32'(n), 16);
    chk("mid.no_valid", 32'(saw), 0);
    read_chk("mid.q11", 1, 1, 0);
    read_chk("mid.q12", 1, 2, 0);
    txn("post", 1, 2, 3, 0, 'h0100, 'h0080, 'h0080, 0, qn, am);
    chk("post.q_const", 32'(o_q_new), 'h0080);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
